// File: rtl/des_sbox_seq.sv
// des_sbox_seq: time-multiplexed DES S-box stage.
// Evaluates LANES of the eight S-boxes per cycle, so a word takes 8/LANES BUSY
// cycles. Valid/ready handshake on both the input and the output side.
// Build option: define SBOX_PERM_EN to drive out_data through the DES
// P-permutation. Without it, out_data is the raw S1..S8 concatenation.
//
// state | meaning
// IDLE  | waiting for an input word
// BUSY  | evaluating one group of LANES S-boxes per cycle
// DONE  | result held on out_data until the consumer takes it

module des_sbox_seq #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int K  = 8 / LANES;
    localparam int GW = (K > 1) ? $clog2(K) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(K - 1);

    // Each table is row-major: entry {row, col} sits in nibble 0 at the MSB end.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [47:0]     operand;
    logic [31:0]     result;
    logic [GW-1:0]   grp;
    logic            accept;
    logic [2:0]      sel [LANES];
    logic [3:0]      nib [LANES];

    // Row is {b5, b0}, column is b[4:1]; box 0 is S1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        logic [5:0] idx;
        idx = {b[5], b[0], b[4:1]};
        return SBOX_TBL[box][8'(255 - 4 * int'(idx)) -: 4];
    endfunction

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    assign accept = in_valid & in_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and handshake outputs; in_ready follows out_ready combinationally in DONE
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (grp == GRP_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // S-box lookups for the group selected by grp
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sel[l] = 3'(int'(grp) * LANES + l);
            nib[l] = sbox_lookup(sel[l], operand[6'(47 - 6 * int'(sel[l])) -: 6]);
        end
    end

    // operand capture, result accumulation and group counter
    always_ff @(posedge clk) begin
        if (rst) begin
            operand <= '0;
            result  <= '0;
            grp     <= '0;
        end else if (accept) begin
            operand <= in_data;
            result  <= '0;
            grp     <= '0;
        end else if (state == BUSY) begin
            for (int l = 0; l < LANES; l++) begin
                result[5'(31 - 4 * int'(sel[l])) -: 4] <= nib[l];
            end
            grp <= grp + GW'(1);
        end
    end

`ifdef SBOX_PERM_EN
    localparam int PERM [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // P-permutation: output bit i (1 = MSB) takes result bit PERM[i-1] (1 = MSB)
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 32; i++) begin
            out_data[5'(31 - i)] = result[5'(32 - PERM[i])];
        end
    end
`else
    assign out_data = result;
`endif

endmodule

// File: tb/tb_des_sbox_seq.sv
// Testbench for des_sbox_seq: one instance per LANES value (1, 2, 4, 8), each
// driven by its own sequence and checked against a table-driven DES S-box model.
module tb_des_sbox_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    localparam int SB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},  '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},  '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},  '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},  '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},  '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},  '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},  '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},  '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},  '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},  '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},  '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},  '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},  '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},  '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},  '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},  '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    localparam int PERM [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam logic [47:0] DIR_IN  [5] = '{48'h000000000000, 48'h000000000001, 48'h082082082082,
                                            48'h555555555555, 48'hFFFFFFFFFFFF};
    localparam logic [31:0] DIR_OUT [5] = '{32'hEFA72C4D, 32'hEFA72C41, 32'h410DC1B2,
                                            32'hC152FD56, 32'hD9CE3DCB};

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: split into eight 6-bit chunks, look each up, concatenate.
    function automatic logic [31:0] ref_sbox(input logic [47:0] d);
        logic [31:0] r;
        logic [31:0] p;
        int six, row, col;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            six = int'((d >> (42 - 6 * b)) & 48'h3F);
            row = (six / 32) * 2 + (six % 2);
            col = (six / 2) % 16;
            r = (r << 4) | 32'(SB[b][row][col]);
        end
        p = r;
`ifdef SBOX_PERM_EN
        p = '0;
        for (int i = 1; i <= 32; i++) begin
            p = p | (((r >> (32 - PERM[i-1])) & 32'h1) << (32 - i));
        end
`endif
        return p;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam int L = 1 << g;
        localparam int K = 8 / L;

        logic        rst;
        logic        in_valid;
        logic        in_ready;
        logic [47:0] in_data;
        logic        out_valid;
        logic        out_ready;
        logic [31:0] out_data;
        logic        busy;
        bit          done = 1'b0;

        des_sbox_seq #(.LANES(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .busy      (busy)
        );

        function automatic string t(input string a, input string b);
            return $sformatf("L%0d.%s.%s", L, a, b);
        endfunction

        // Called at the first negedge after the accept edge; returns at the
        // sample point of the cycle where out_valid is first seen.
        task automatic collect(input logic [31:0] exp, input string tag);
            int lat, bcnt, ir_bad;
            in_valid = 1'b0;
            in_data  = '0;
            #1;
            lat = 0; bcnt = 0; ir_bad = 0;
            while (!out_valid && lat < 20) begin
                bcnt += int'(busy);
                if (in_ready) ir_bad++;
                @(negedge clk); #1;
                lat++;
            end
            chk_eq(t(tag, "latency"), 64'(lat), 64'(K));
            chk_eq(t(tag, "busy_cycles"), 64'(bcnt), 64'(K));
            chk_eq(t(tag, "in_ready_busy"), 64'(ir_bad), 64'd0);
            chk_eq(t(tag, "busy_done"), 64'(busy), 64'd0);
            chk_eq(t(tag, "data"), 64'(out_data), 64'(exp));
        endtask

        task automatic run_word(input logic [47:0] d, input logic [31:0] exp, input string tag);
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = 1'b1;
            #1;
            chk_eq(t(tag, "in_ready_idle"), 64'(in_ready), 64'd1);
            @(negedge clk);
            collect(exp, tag);
            @(negedge clk); #1;
            chk_eq(t(tag, "consumed"), 64'(out_valid), 64'd0);
        endtask

        task automatic backpressure(input logic [47:0] d0, input logic [47:0] d1);
            int bad_data, bad_ir, bad_ov;
            in_valid  = 1'b1;
            in_data   = d0;
            out_ready = 1'b0;
            @(negedge clk);
            collect(ref_sbox(d0), "bp0");
            bad_data = 0; bad_ir = 0; bad_ov = 0;
            for (int c = 0; c < 5; c++) begin
                in_valid = (c % 2 == 0);
                in_data  = {16'($urandom), $urandom};
                #1;
                if (out_data !== ref_sbox(d0)) bad_data++;
                if (in_ready !== 1'b0) bad_ir++;
                if (out_valid !== 1'b1) bad_ov++;
                @(negedge clk); #1;
            end
            chk_eq(t("bp", "hold_data"), 64'(bad_data), 64'd0);
            chk_eq(t("bp", "hold_in_ready"), 64'(bad_ir), 64'd0);
            chk_eq(t("bp", "hold_out_valid"), 64'(bad_ov), 64'd0);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = d1;
            #1;
            chk_eq(t("bp", "in_ready_release"), 64'(in_ready), 64'd1);
            @(negedge clk);
            collect(ref_sbox(d1), "bp1");
            @(negedge clk); #1;
            chk_eq(t("bp1", "consumed"), 64'(out_valid), 64'd0);
        endtask

        task automatic stream();
            logic [47:0] words [$];
            logic [31:0] q [$];
            logic [31:0] exp;
            int got, last, bad_gap;
            for (int i = 0; i < 4; i++) words.push_back({16'($urandom), $urandom});
            got = 0; last = -1; bad_gap = 0;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
                in_valid = (words.size() > 0);
                in_data  = (words.size() > 0) ? words[0] : 48'h0;
                #1;
                if (out_valid) begin
                    exp = (q.size() > 0) ? q.pop_front() : 32'h0;
                    chk_eq(t("stream", $sformatf("data%0d", got)), 64'(out_data), 64'(exp));
                    if (last >= 0 && cyc - last != K + 1) bad_gap++;
                    last = cyc;
                    got++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(ref_sbox(words.pop_front()));
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            #1;
            chk_eq(t("stream", "count"), 64'(got), 64'd4);
            chk_eq(t("stream", "spacing"), 64'(bad_gap), 64'd0);
        endtask

        task automatic reset_mid_busy(input logic [47:0] d);
            int stop, stale;
            stop = (K >= 3) ? 2 : K - 1;
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (stop) @(negedge clk);
            #1;
            chk_eq(t("rst_busy", "busy_before"), 64'(busy), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk_eq(t("rst_busy", "out_valid"), 64'(out_valid), 64'd0);
            chk_eq(t("rst_busy", "out_data"), 64'(out_data), 64'd0);
            chk_eq(t("rst_busy", "in_ready"), 64'(in_ready), 64'd1);
            chk_eq(t("rst_busy", "busy"), 64'(busy), 64'd0);
            stale = 0;
            repeat (K + 2) begin
                @(negedge clk); #1;
                if (out_valid || busy) stale++;
            end
            chk_eq(t("rst_busy", "stale"), 64'(stale), 64'd0);
        endtask

        initial begin
            logic [47:0] d;
            logic [31:0] exp;
            rst       = 1'b1;
            in_valid  = 1'b1;
            in_data   = {16'($urandom), $urandom};
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk_eq(t("reset", "out_valid"), 64'(out_valid), 64'd0);
            chk_eq(t("reset", "busy"), 64'(busy), 64'd0);
            chk_eq(t("reset", "out_data"), 64'(out_data), 64'd0);
            chk_eq(t("reset", "in_ready"), 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            rst      = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 5; i++) begin
`ifdef SBOX_PERM_EN
                exp = (DIR_IN[i] == 48'h0) ? 32'hD8D8DBBC : ref_sbox(DIR_IN[i]);
`else
                exp = DIR_OUT[i];
`endif
                run_word(DIR_IN[i], exp, $sformatf("dir%0d", i));
            end

            for (int i = 0; i < 12; i++) begin
                d = {16'($urandom), $urandom};
                run_word(d, ref_sbox(d), $sformatf("rnd%0d", i));
            end

            backpressure({16'($urandom), $urandom}, {16'($urandom), $urandom});
            stream();
            reset_mid_busy({16'($urandom), $urandom});
            d = {16'($urandom), $urandom};
            run_word(d, ref_sbox(d), "after_rst");
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done && g_lane[3].done)
               && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk_eq("all_lanes_done",
               64'({g_lane[3].done, g_lane[2].done, g_lane[1].done, g_lane[0].done}), 64'hF);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
